// File: rtl/hififo_pkg.sv
// hififo_pkg: shared tag layout, PIO address map and helpers for the hififo DMA blocks.
package hififo_pkg;
    localparam int TAG_W = 8;
    localparam int TAG_SEQ_LSB = 0;
    localparam logic [12:0] PIO_ENABLE_ADDR = 13'd16;
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/hififo_rr_pick.sv
// hififo_rr_pick: combinational round-robin picker, first request at or after ptr wins.
module hififo_rr_pick #(
    parameter int N = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        // Walk from the farthest offset down so the nearest request is written last.
        for (int i = N - 1; i >= 0; i--) if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
        any = |req;
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/hififo_rr_arbiter.sv
// hififo_rr_arbiter: round-robin merge of per-channel read requests with tag
// allocation, outstanding-tag tracking and a PIO channel-enable mask.
module hififo_rr_arbiter import hififo_pkg::*; #(
    parameter int NCH = 4,
    parameter int SEQ_BITS = 3,
    parameter logic [12:0] ENABLE_ADDR = PIO_ENABLE_ADDR
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pio_wvalid,
    input  logic [12:0]                pio_addr,
    input  logic [63:0]                pio_wdata,
    input  logic [NCH-1:0]             rr_valid,
    output logic [NCH-1:0]             rr_ready,
    input  logic [NCH*64-1:0]          rr_addr,
    output logic                       rrm_valid,
    input  logic                       rrm_ready,
    output logic [63:0]                rrm_addr,
    output logic [TAG_W-1:0]           rrm_tag,
    input  logic                       rc_done,
    input  logic [TAG_W-1:0]           rc_tag,
    output logic [NCH*(1<<SEQ_BITS)-1:0] busy,
    output logic                       tag_error,
    output logic                       idle
);
    localparam int CH_BITS = (NCH > 1) ? clog2(NCH) : 1;
    localparam int NS = 1 << SEQ_BITS;

    logic [NCH-1:0][NS-1:0] busy_q, busy_nxt;
    logic [NCH-1:0][SEQ_BITS-1:0] seq_ptr;
    logic [NCH-1:0] enable, eligible, gnt;
    logic [CH_BITS-1:0] rr_ptr, gidx, rc_ch;
    logic [SEQ_BITS-1:0] rc_seq;
    logic slot_free, any, rc_ok, unused_bits;

    assign unused_bits = ^pio_wdata;
    assign busy = busy_q;
    assign rr_ready = gnt;
    assign slot_free = !rrm_valid || rrm_ready;
    assign idle = busy_q == '0 && !rrm_valid;
    assign rc_seq = rc_tag[TAG_SEQ_LSB +: SEQ_BITS];
    assign rc_ch = rc_tag[SEQ_BITS +: CH_BITS];
    // Channel field plus zero pad must name a real channel before the busy lookup counts.
    assign rc_ok = int'(rc_tag >> SEQ_BITS) < NCH && busy_q[rc_ch][rc_seq];

    always_comb begin
        for (int k = 0; k < NCH; k++) eligible[k] = rr_valid[k] & enable[k] & ~busy_q[k][seq_ptr[k]];
    end

    hififo_rr_pick #(.N(NCH), .IW(CH_BITS)) u_pick (
        .req(eligible & {NCH{slot_free}}),
        .ptr(rr_ptr),
        .gnt(gnt),
        .idx(gidx),
        .any(any)
    );

    always_comb begin
        busy_nxt = busy_q;
        if (any) busy_nxt[gidx][seq_ptr[gidx]] = 1'b1;
        if (rc_done && rc_ok) busy_nxt[rc_ch][rc_seq] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable <= '0;
            seq_ptr <= '0;
            rr_ptr <= '0;
            busy_q <= '0;
            rrm_valid <= 1'b0;
            rrm_addr <= '0;
            rrm_tag <= '0;
            tag_error <= 1'b0;
        end else begin
            if (pio_wvalid && pio_addr == ENABLE_ADDR) enable <= pio_wdata[NCH-1:0];
            if (slot_free) rrm_valid <= any;
            if (any) begin
                rrm_addr <= rr_addr[int'(gidx)*64 +: 64];
                rrm_tag <= TAG_W'({gidx, seq_ptr[gidx]});
                seq_ptr[gidx] <= seq_ptr[gidx] + 1'b1;
                rr_ptr <= (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
            end
            busy_q <= busy_nxt;
            if (rc_done && !rc_ok) tag_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hififo_rr_arbiter.sv
// tb_hififo_rr_arbiter: directed-vector bench for hififo_rr_arbiter (NCH=4, SEQ_BITS=3).
module tb_hififo_rr_arbiter;
    logic clock = 1'b0;
    logic reset;
    logic pio_wvalid;
    logic [12:0] pio_addr;
    logic [63:0] pio_wdata;
    logic [3:0] rr_valid, rr_ready;
    logic [255:0] rr_addr;
    logic rrm_valid, rrm_ready;
    logic [63:0] rrm_addr;
    logic [7:0] rrm_tag, rc_tag;
    logic rc_done;
    logic [31:0] busy;
    logic tag_error, idle;
    int vectors = 0;
    int miscompares = 0;

    hififo_rr_arbiter #(.NCH(4), .SEQ_BITS(3), .ENABLE_ADDR(13'd16)) dut (
        .clock(clock), .reset(reset), .pio_wvalid(pio_wvalid), .pio_addr(pio_addr),
        .pio_wdata(pio_wdata), .rr_valid(rr_valid), .rr_ready(rr_ready), .rr_addr(rr_addr),
        .rrm_valid(rrm_valid), .rrm_ready(rrm_ready), .rrm_addr(rrm_addr), .rrm_tag(rrm_tag),
        .rc_done(rc_done), .rc_tag(rc_tag), .busy(busy), .tag_error(tag_error), .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic pio_enable(input logic [3:0] m);
        pio_wvalid = 1'b1;
        pio_addr = 13'd16;
        pio_wdata = {60'h0, m};
        cyc();
        pio_wvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pio_wvalid = 1'b0;
        pio_addr = '0;
        pio_wdata = '0;
        rr_valid = '0;
        rr_addr = '0;
        rrm_ready = 1'b1;
        rc_done = 1'b0;
        rc_tag = '0;
        cyc();
        cyc();
        chk("rst_rr_ready", rr_ready, 0);
        chk("rst_rrm_valid", rrm_valid, 0);
        chk("rst_rrm_addr", rrm_addr, 0);
        chk("rst_rrm_tag", rrm_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tag_error", tag_error, 0);
        chk("rst_idle", idle, 1);
        reset = 1'b0;

        // single request on ch0; enable write only counts from the next cycle
        pio_wvalid = 1'b1;
        pio_addr = 13'd16;
        pio_wdata = 64'h1;
        rr_valid = 4'b0001;
        rr_addr[63:0] = 64'h1000;
        #1 chk("t1_enable_late", rr_ready, 0);
        cyc();
        pio_wvalid = 1'b0;
        #1 chk("t1_rr_ready", rr_ready, 4'b0001);
        cyc();
        chk("t1_rrm_valid", rrm_valid, 1);
        chk("t1_rrm_addr", rrm_addr, 64'h1000);
        chk("t1_rrm_tag", rrm_tag, 8'h00);
        chk("t1_busy", busy, 32'h1);
        rr_valid = 4'b0000;
        #1 chk("t1_no_ready", rr_ready, 0);
        cyc();
        chk("t1_valid_drop", rrm_valid, 0);
        chk("t1_not_idle", idle, 0);

        // four channels continuously requesting
        do_reset();
        pio_enable(4'hF);
        for (int k = 0; k < 4; k++) rr_addr[64*k +: 64] = 64'h2000 + 64'(k) * 64'h100;
        rr_valid = 4'hF;
        #1 chk("t2_g0", rr_ready, 4'b0001);
        cyc();
        chk("t2_tag0", rrm_tag, 8'h00);
        chk("t2_addr0", rrm_addr, 64'h2000);
        chk("t2_g1", rr_ready, 4'b0010);
        cyc();
        chk("t2_tag1", rrm_tag, 8'h08);
        chk("t2_addr1", rrm_addr, 64'h2100);
        chk("t2_g2", rr_ready, 4'b0100);
        cyc();
        chk("t2_tag2", rrm_tag, 8'h10);
        chk("t2_g3", rr_ready, 4'b1000);
        cyc();
        chk("t2_tag3", rrm_tag, 8'h18);
        chk("t2_addr3", rrm_addr, 64'h2300);
        chk("t2_g4", rr_ready, 4'b0001);
        cyc();
        chk("t2_tag4", rrm_tag, 8'h01);
        chk("t2_valid4", rrm_valid, 1);
        rr_valid = 4'h0;
        cyc();
        chk("t2_busy", busy, 32'h01010103);
        chk("t2_valid_drop", rrm_valid, 0);

        // ch1 exhausts its eight tags, then one completion frees tag 0x08
        do_reset();
        pio_enable(4'b0010);
        rr_addr[127:64] = 64'h3000;
        rr_valid = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            #1 chk("t3_grant", rr_ready, 4'b0010);
            cyc();
            chk("t3_tag", rrm_tag, 64'h08 + 64'(i));
        end
        #1 chk("t3_stall", rr_ready, 0);
        cyc();
        chk("t3_stall_valid", rrm_valid, 0);
        chk("t3_busy_full", busy, 32'h0000FF00);
        rc_done = 1'b1;
        rc_tag = 8'h08;
        #1 chk("t3_not_same_cycle", rr_ready, 0);
        cyc();
        rc_done = 1'b0;
        chk("t3_freed", busy, 32'h0000FE00);
        #1 chk("t3_regrant", rr_ready, 4'b0010);
        cyc();
        chk("t3_reuse_valid", rrm_valid, 1);
        chk("t3_reuse_tag", rrm_tag, 8'h08);
        rr_valid = 4'b0000;

        // output held by backpressure while ch2 waits
        rrm_ready = 1'b0;
        pio_enable(4'b0100);
        rr_addr[191:128] = 64'h4000;
        rr_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t4_hold_ready", rr_ready, 0);
            chk("t4_hold_valid", rrm_valid, 1);
            chk("t4_hold_tag", rrm_tag, 8'h08);
            chk("t4_hold_addr", rrm_addr, 64'h3000);
            cyc();
        end
        rrm_ready = 1'b1;
        #1 chk("t4_release", rr_ready, 4'b0100);
        cyc();
        chk("t4_tag", rrm_tag, 8'h10);
        chk("t4_addr", rrm_addr, 64'h4000);
        rr_valid = 4'b0000;
        cyc();
        chk("t4_valid_drop", rrm_valid, 0);
        chk("t4_busy", busy, 32'h0001FF00);

        // completion for a tag never issued
        rc_done = 1'b1;
        rc_tag = 8'h03;
        cyc();
        rc_done = 1'b0;
        chk("t5_tag_error", tag_error, 1);
        chk("t5_busy_same", busy, 32'h0001FF00);
        cyc();
        cyc();
        chk("t5_sticky", tag_error, 1);

        // disable ch0 with two tags outstanding
        do_reset();
        chk("t6_err_cleared", tag_error, 0);
        pio_enable(4'b0001);
        rr_addr[63:0] = 64'h5000;
        rr_valid = 4'b0001;
        cyc();
        chk("t6_tag0", rrm_tag, 8'h00);
        cyc();
        chk("t6_tag1", rrm_tag, 8'h01);
        rr_valid = 4'b0000;
        pio_enable(4'b0000);
        rr_valid = 4'b0001;
        #1 chk("t6_no_grant", rr_ready, 0);
        chk("t6_busy", busy, 32'h3);
        chk("t6_not_idle", idle, 0);
        rc_done = 1'b1;
        rc_tag = 8'h00;
        cyc();
        rc_tag = 8'h01;
        cyc();
        rc_done = 1'b0;
        chk("t6_busy_clear", busy, 0);
        chk("t6_idle", idle, 1);
        chk("t6_still_blocked", rr_ready, 0);
        chk("t6_no_error", tag_error, 0);
        rr_valid = 4'b0000;

        // asynchronous reset in the middle of a burst
        pio_enable(4'hF);
        rr_valid = 4'hF;
        cyc();
        chk("t7_first_tag", rrm_tag, 8'h08);
        cyc();
        chk("t7_second_tag", rrm_tag, 8'h10);
        #2 reset = 1'b1;
        #1 chk("t7_async_valid", rrm_valid, 0);
        chk("t7_async_addr", rrm_addr, 0);
        chk("t7_async_tag", rrm_tag, 0);
        chk("t7_async_busy", busy, 0);
        chk("t7_async_idle", idle, 1);
        chk("t7_async_ready", rr_ready, 0);
        rr_valid = 4'h0;
        cyc();
        reset = 1'b0;
        rc_done = 1'b1;
        rc_tag = 8'h10;
        cyc();
        rc_done = 1'b0;
        chk("t7_stale_error", tag_error, 1);
        chk("t7_stale_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hififo_rr_arbiter.md
# hififo_rr_arbiter

Parametrised read-request arbiter and tag manager for the from-PC DMA path. Merges read requests from NCH from-PC FIFO channels onto the single PCIe TX read-request port using round-robin arbitration. Allocates a unique tag per request and tracks outstanding tags until the RX side signals completion. Gates each channel with a PIO-writable enable mask.

## Interface
- NCH, 4: number of requester channels, 1..8
- SEQ_BITS, 3: per-channel tag sequence bits; 2^SEQ_BITS outstanding requests per channel; CH_BITS = max(1, clog2(NCH)); CH_BITS+SEQ_BITS ≤ 8
- ENABLE_ADDR, 13'd16: PIO address of the channel-enable register
- clock  in  1  system clock (PCIe user clock)
- reset  in  1  asynchronous, active-high reset
- pio_wvalid  in  1  PIO write strobe
- pio_addr  in  13  PIO word address
- pio_wdata  in  64  PIO write data; bits [NCH-1:0] = channel enable
- rr_valid  in  NCH  per-channel request valid
- rr_ready  out  NCH  per-channel accept; combinational; one-hot or zero
- rr_addr  in  NCH*64  per-channel request address; channel k at [64k+63:64k]
- rrm_valid  out  1  merged request valid (registered)
- rrm_ready  in  1  TX accepts merged request
- rrm_addr  out  64  merged request address (registered)
- rrm_tag  out  8  tag = {zero pad, channel[CH_BITS-1:0], seq[SEQ_BITS-1:0]}
- rc_done  in  1  completion of a whole read request (last completion TLP)
- rc_tag  in  8  tag of the completed request
- busy  out  NCH*2^SEQ_BITS  outstanding-tag bitmap, channel-major
- tag_error  out  1  sticky: rc_done seen for a tag not outstanding
- idle  out  1  no tag outstanding and rrm_valid low

## Operation
- Enable register: written when pio_wvalid && pio_addr == ENABLE_ADDR. Reset value is all zero, so all channels start disabled.
- Channel k is eligible when rr_valid[k], enable[k], and busy[k][seq_ptr[k]] == 0.
- Output slot is free when !rrm_valid || rrm_ready.
- Grant rule: when the slot is free and at least one channel is eligible, grant the first eligible channel at or after rr_ptr in ascending modulo order.
  - rr_ready[grant] = 1 in that cycle.
  - Next cycle: rrm_valid = 1, rrm_addr = that channel's rr_addr, rrm_tag = {grant, seq_ptr[grant]}.
  - On the clock edge: busy bit set, seq_ptr[grant] += 1 (wraps mod 2^SEQ_BITS), rr_ptr = grant+1 mod NCH.
- If the slot is free and no channel is eligible, rrm_valid deasserts.
- Holding: while rrm_valid && !rrm_ready, rrm_addr and rrm_tag stay stable and rr_ready stays 0.
- Completion: rc_done clears busy[rc_tag]. If that bit is already clear, or the channel field is ≥ NCH, set tag_error (sticky until reset) and change no state.
- Disabling a channel mid-operation:
  - Its outstanding tags remain and are still cleared by completions.
  - A request already in the output register is still presented.
  - No new grants go to that channel.
- Requesters hold rr_valid and rr_addr stable until rr_ready. The arbiter does not check this.

## Timing
- Reset values: rr_ready 0, rrm_valid 0, rrm_addr 0, rrm_tag 0, busy 0, tag_error 0, idle 1, enable 0, seq_ptr 0, rr_ptr 0.
- Request latency: request accepted (rr_ready) in cycle n → rrm_valid in cycle n+1.
- Back-to-back throughput: one request per cycle while rrm_ready stays high.
- A busy bit freed by rc_done in cycle n is usable for a grant in cycle n+1, not in cycle n.
- rc_done in the same cycle as a grant: both take effect. They never target the same tag, because a granted tag is not busy.
- A PIO enable write in cycle n affects eligibility from cycle n+1.
- Reset asserted mid-transfer: all state clears immediately. Completions for pre-reset tags arriving later raise tag_error.

## Structure
- Shared package hififo_pkg holds:
  - the tag layout constants (TAG_W = 8, field offsets)
  - the PIO address constant for ENABLE_ADDR
  - a function clog2
- One sub-module: hififo_rr_pick, a combinational round-robin priority picker (NCH request bits plus pointer → one-hot grant and index). It is reused by later TX write arbitration.

## Test plan
- Reset then enable = 4'b0001; ch0 requests addr 0x1000 → rr_ready[0] in cycle n, rrm_valid/addr 0x1000/tag 0x00 in n+1, busy[0] = 1.
- All four channels enabled and requesting continuously, rrm_ready = 1 → tags granted in order ch0, ch1, ch2, ch3, ch0, with ch0's second tag = 0x01.
- ch1 issues 8 requests with no completions → ninth stalls (rr_ready[1] stays 0); rc_done tag 0x08 → ch1 granted the cycle after, tag 0x08 reused.
- rrm_ready held low 5 cycles with ch2 pending → rrm_addr/rrm_tag stable, no rr_ready pulses; then rrm_ready = 1 → next grant issued in the same cycle.
- rc_done with tag 0x03 never issued → tag_error = 1 and busy unchanged; tag_error stays set until reset.
- Channel 0 disabled with 2 outstanding tags → no new ch0 grants; 2 completions clear busy and idle rises; reset mid-burst → all outputs return to their reset values asynchronously.
